// File: rtl/cpu_run_controller_pkg.sv
// Shared constants for the CPU run controller.
// State codes, halt-cause codes and channel slicing helper.
package cpu_run_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RESET = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] HALT_NONE    = 2'b00;
  localparam logic [1:0] HALT_STALL   = 2'b01;
  localparam logic [1:0] HALT_EXT     = 2'b10;
  localparam logic [1:0] HALT_TIMEOUT = 2'b11;

  function automatic int ch_lo(
    input int k,
    input int w
  );
    return k * w;
  endfunction

endpackage

// File: rtl/cpu_run_controller_if.sv
// Bundle between the run controller and its host/CPU side.
// master drives stimulus, slave is the controller.
interface cpu_run_controller_if #(
  parameter int DATA_W     = 32,
  parameter int N_CH       = 4,
  parameter int PC_W       = 32,
  parameter int MAX_CYCLES = 1500
);

  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  logic                   start;
  logic                   halt_in;
  logic [PC_W-1:0]        pc;
  logic [N_CH*DATA_W-1:0] result_data;
  logic [N_CH*DATA_W-1:0] expect_data;
  logic [N_CH-1:0]        expect_mask;

  logic                   cpu_reset;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [N_CH-1:0]        fail_mask;
  logic [1:0]             halt_cause;
  logic [CNT_W-1:0]       cycle_count;

  modport master (
    output start,
    output halt_in,
    output pc,
    output result_data,
    output expect_data,
    output expect_mask,
    input  cpu_reset,
    input  busy,
    input  done,
    input  pass,
    input  fail_mask,
    input  halt_cause,
    input  cycle_count
  );

  modport slave (
    input  start,
    input  halt_in,
    input  pc,
    input  result_data,
    input  expect_data,
    input  expect_mask,
    output cpu_reset,
    output busy,
    output done,
    output pass,
    output fail_mask,
    output halt_cause,
    output cycle_count
  );

endinterface

// File: rtl/cpu_run_controller_halt_detector.sv
// PC stagnation detector: flags the cycle on which the PC has
// held one value for STALL_LIMIT consecutive enabled cycles.
module halt_detector #(
  parameter int PC_W        = 32,
  parameter int STALL_LIMIT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  input  logic [PC_W-1:0] pc,
  output logic            stalled
);

  localparam int SW = $clog2(STALL_LIMIT);
  localparam logic [SW-1:0] CNT_TOP = SW'(STALL_LIMIT - 1);
  localparam logic [SW-1:0] CNT_HIT = SW'(STALL_LIMIT - 2);

  logic [PC_W-1:0] prev_pc;
  logic            prev_vld;
  logic [SW-1:0]   cnt;
  logic            same;

  // The first enabled cycle only captures a reference PC.
  assign same    = prev_vld && (pc == prev_pc);
  assign stalled = enable && same && (cnt == CNT_HIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_pc  <= '0;
      prev_vld <= 1'b0;
      cnt      <= '0;
    end else if (clear) begin
      prev_pc  <= '0;
      prev_vld <= 1'b0;
      cnt      <= '0;
    end else if (enable) begin
      prev_pc  <= pc;
      prev_vld <= 1'b1;
      if (!same)
        cnt <= '0;
      else if (cnt != CNT_TOP)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Run harness: sequences CPU reset, times the run, detects
// completion and checks watched registers against expectations.
module cpu_run_controller
  import cpu_run_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int N_CH        = 4,
  parameter int PC_W        = 32,
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 1500,
  parameter int STALL_LIMIT = 16,
  parameter int CNT_W       = $clog2(MAX_CYCLES + 1)
) (
  input logic                 clk,
  input logic                 reset,
  cpu_run_controller_if.slave bus
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [RW-1:0]    RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  logic [2:0]       state;
  logic [RW-1:0]    rst_cnt;
  logic             cpu_reset_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [N_CH-1:0]  fail_q;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] count_q;

  logic             run;
  logic             accept;
  logic             stalled;
  logic             timeout_hit;
  logic             halt_any;
  logic [1:0]       cause_c;
  logic [N_CH-1:0]  fail_c;

  assign run         = (state == S_RUN);
  assign accept      = bus.start &&
                       ((state == S_IDLE) || (state == S_DONE));
  assign timeout_hit = (count_q == CNT_LAST);
  assign halt_any    = run && (cause_c != HALT_NONE);

  always_comb begin
    cause_c = HALT_NONE;
    priority case (1'b1)
      bus.halt_in: cause_c = HALT_EXT;
      stalled:     cause_c = HALT_STALL;
      timeout_hit: cause_c = HALT_TIMEOUT;
      default:     cause_c = HALT_NONE;
    endcase
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_cmp
    localparam int LO = ch_lo(k, DATA_W);
    assign fail_c[k] = bus.expect_mask[k] &&
      (bus.result_data[LO +: DATA_W] !=
       bus.expect_data[LO +: DATA_W]);
  end

  halt_detector #(
    .PC_W       (PC_W),
    .STALL_LIMIT(STALL_LIMIT)
  ) u_halt (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (run),
    .pc     (bus.pc),
    .stalled(stalled)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rst_cnt     <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= '0;
      cause_q     <= HALT_NONE;
      count_q     <= '0;
    end else if (accept) begin
      state       <= S_RESET;
      rst_cnt     <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= '0;
      cause_q     <= HALT_NONE;
      count_q     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cpu_reset_q <= 1'b1;
        end
        S_RESET: begin
          if (rst_cnt == RST_LAST) begin
            state       <= S_RUN;
            cpu_reset_q <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (count_q != CNT_MAX)
            count_q <= count_q + 1'b1;
          if (halt_any) begin
            state   <= S_CHECK;
            cause_q <= cause_c;
          end
        end
        S_CHECK: begin
          fail_q <= fail_c;
          pass_q <= (cause_q != HALT_TIMEOUT) &&
                    (fail_c == '0);
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b1;
        end
        default: begin
          state       <= S_IDLE;
          cpu_reset_q <= 1'b1;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.fail_mask   = fail_q;
  assign bus.halt_cause  = cause_q;
  assign bus.cycle_count = count_q;

endmodule
